// File: rtl/sump_pkg.sv
// sump_pkg: opcodes, field widths and FSM encoding shared by the command decoder
package sump_pkg;
  localparam int OP_W    = 8;
  localparam int DATA_W  = 32;
  localparam int CMD_W   = OP_W + DATA_W;
  localparam int DIV_W   = 24;
  localparam int CNT_W   = 16;
  localparam int FLAGS_W = 11;
  localparam int SR_W    = 3;
  localparam int STAGES  = 4;
  localparam logic [OP_W-1:0] OP_RESET = 8'h00;
  localparam logic [OP_W-1:0] OP_ARM   = 8'h01;
  localparam logic [OP_W-1:0] OP_DIV   = 8'h80;
  localparam logic [OP_W-1:0] OP_COUNT = 8'h81;
  localparam logic [OP_W-1:0] OP_FLAGS = 8'h82;
  localparam logic [3:0] OP_TRIG_HI  = 4'hC;
  localparam logic [1:0] TRIG_MASK   = 2'd0;
  localparam logic [1:0] TRIG_VALUE  = 2'd1;
  localparam logic [1:0] TRIG_CONFIG = 2'd2;
  typedef enum logic {IDLE, ARMED} state_e;
endpackage

// File: rtl/cmd_decoder.sv
// cmd_decoder: turns edge-qualified UART commands into register loads, trigger write strobes and arm/soft-reset pulses
module cmd_decoder import sump_pkg::*; #(
  parameter logic [DIV_W-1:0] DIV_RESET    = 24'd0,
  parameter logic [SR_W-1:0]  RESET_REPEAT = 3'd5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 execute,
  input  logic [CMD_W-1:0]     cmd,
  input  logic                 capture_done,
  output logic                 soft_reset,
  output logic                 arm,
  output logic                 armed,
  output logic [STAGES-1:0]    wr_mask,
  output logic [STAGES-1:0]    wr_value,
  output logic [STAGES-1:0]    wr_config,
  output logic [DATA_W-1:0]    wr_data,
  output logic [DIV_W-1:0]     divider,
  output logic [CNT_W-1:0]     read_count,
  output logic [CNT_W-1:0]     delay_count,
  output logic [FLAGS_W-1:0]   flags
);
  logic [OP_W-1:0]    op;
  logic [DATA_W-1:0]  od;
  logic               acc, trig;
  logic [STAGES-1:0]  sel;
  logic [SR_W-1:0]    cnt_inc;
  logic               exec_q, rdy_q;
  state_e             state_q, state_d;
  logic [SR_W-1:0]    cnt_q, cnt_d;
  logic               srst_q, srst_d, arm_q, arm_d;
  logic [STAGES-1:0]  mask_q, mask_d, value_q, value_d, config_q, config_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   rcnt_q, rcnt_d, dcnt_q, dcnt_d;
  logic [FLAGS_W-1:0] flags_q, flags_d;
  assign op   = cmd[OP_W-1:0];
  assign od   = cmd[CMD_W-1:OP_W];
  // rdy_q blocks acceptance until execute has been seen low after reset, so a held execute is never taken as a new edge
  assign acc  = execute & ~exec_q & rdy_q;
  assign trig = acc && op[7:4] == OP_TRIG_HI;
  assign sel  = STAGES'(1) << op[3:2];
  // next-state for the FSM, soft-reset counter and all registered outputs; soft reset overrides everything else
  always_comb begin
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + SR_W'(1);
    srst_d   = acc && op == OP_RESET && cnt_inc == RESET_REPEAT;
    cnt_d    = !acc ? cnt_q : (op != OP_RESET || srst_d) ? '0 : cnt_inc;
    arm_d    = !srst_d && acc && op == OP_ARM && state_q == IDLE;
    state_d  = srst_d ? IDLE : arm_d ? ARMED : (state_q == ARMED && capture_done) ? IDLE : state_q;
    mask_d   = (trig && op[1:0] == TRIG_MASK)   ? sel : '0;
    value_d  = (trig && op[1:0] == TRIG_VALUE)  ? sel : '0;
    config_d = (trig && op[1:0] == TRIG_CONFIG) ? sel : '0;
    wdata_d  = |{mask_d, value_d, config_d} ? od : wdata_q;
    div_d    = srst_d ? DIV_RESET : (acc && op == OP_DIV) ? od[DIV_W-1:0] : div_q;
    rcnt_d   = srst_d ? '0 : (acc && op == OP_COUNT) ? od[CNT_W-1:0] : rcnt_q;
    dcnt_d   = srst_d ? '0 : (acc && op == OP_COUNT) ? od[DATA_W-1:CNT_W] : dcnt_q;
    flags_d  = srst_d ? '0 : (acc && op == OP_FLAGS) ? od[FLAGS_W-1:0] : flags_q;
  end
  // state and output registers, cleared asynchronously by reset_n
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exec_q   <= 1'b0;
      rdy_q    <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      srst_q   <= 1'b0;
      arm_q    <= 1'b0;
      mask_q   <= '0;
      value_q  <= '0;
      config_q <= '0;
      wdata_q  <= '0;
      div_q    <= DIV_RESET;
      rcnt_q   <= '0;
      dcnt_q   <= '0;
      flags_q  <= '0;
    end else begin
      exec_q   <= execute;
      rdy_q    <= rdy_q | ~execute;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      srst_q   <= srst_d;
      arm_q    <= arm_d;
      mask_q   <= mask_d;
      value_q  <= value_d;
      config_q <= config_d;
      wdata_q  <= wdata_d;
      div_q    <= div_d;
      rcnt_q   <= rcnt_d;
      dcnt_q   <= dcnt_d;
      flags_q  <= flags_d;
    end
  end
  assign soft_reset  = srst_q;
  assign arm         = arm_q;
  assign armed       = state_q == ARMED;
  assign wr_mask     = mask_q;
  assign wr_value    = value_q;
  assign wr_config   = config_q;
  assign wr_data     = wdata_q;
  assign divider     = div_q;
  assign read_count  = rcnt_q;
  assign delay_count = dcnt_q;
  assign flags       = flags_q;
endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: directed and random commands checked cycle by cycle against a behavioural model
module tb_cmd_decoder;
  localparam logic [23:0] DIV_RST = 24'd0;
  localparam int          REPEAT  = 5;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        execute = 1'b0;
  logic [39:0] cmd = '0;
  logic        capture_done = 1'b0;
  logic        soft_reset, arm, armed;
  logic [3:0]  wr_mask, wr_value, wr_config;
  logic [31:0] wr_data;
  logic [23:0] divider;
  logic [15:0] read_count, delay_count;
  logic [10:0] flags;
  int errs = 0, checks = 0;
  int n_srst = 0, n_arm = 0, n_mask = 0;
  logic        m_srst, m_arm, m_armed, m_prev, m_seen;
  logic [3:0]  m_mask, m_val, m_cfg;
  logic [31:0] m_wdata;
  logic [23:0] m_div;
  logic [15:0] m_rc, m_dc;
  logic [10:0] m_fl;
  int          m_zeros;

  cmd_decoder dut (
    .clock(clock), .reset_n(reset_n), .execute(execute), .cmd(cmd),
    .capture_done(capture_done), .soft_reset(soft_reset), .arm(arm), .armed(armed),
    .wr_mask(wr_mask), .wr_value(wr_value), .wr_config(wr_config), .wr_data(wr_data),
    .divider(divider), .read_count(read_count), .delay_count(delay_count), .flags(flags)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    {m_srst, m_arm, m_armed, m_prev, m_seen} = '0;
    {m_mask, m_val, m_cfg} = '0;
    m_wdata = '0; m_div = DIV_RST; m_rc = '0; m_dc = '0; m_fl = '0; m_zeros = 0;
  endtask

  task automatic model(input logic e, input logic [39:0] c, input logic cd);
    logic acc, was_armed;
    int op, k;
    logic [31:0] d;
    was_armed = m_armed;
    {m_srst, m_arm, m_mask, m_val, m_cfg} = '0;
    acc = e && !m_prev && m_seen;
    m_prev = e;
    if (!e) m_seen = 1'b1;
    op = int'(c % 40'h100);
    d = 32'(c / 40'h100);
    if (acc && op == 0) begin
      m_zeros = (m_zeros < 7) ? m_zeros + 1 : 7;
      if (m_zeros == REPEAT) begin m_srst = 1'b1; m_zeros = 0; end
    end else if (acc) m_zeros = 0;
    if (m_srst) begin
      m_div = DIV_RST; m_rc = '0; m_dc = '0; m_fl = '0; m_armed = 1'b0;
    end else begin
      if (acc) begin
        if (op == 1 && !was_armed) begin m_arm = 1'b1; m_armed = 1'b1; end
        if (op >= 'hC0 && op <= 'hCF && op % 4 != 3) begin
          k = op - 'hC0;
          if (k % 4 == 0) m_mask = 4'(1 << (k / 4));
          if (k % 4 == 1) m_val  = 4'(1 << (k / 4));
          if (k % 4 == 2) m_cfg  = 4'(1 << (k / 4));
          m_wdata = d;
        end
        if (op == 'h80) m_div = 24'(d % 32'h0100_0000);
        if (op == 'h81) begin m_rc = 16'(d % 32'h1_0000); m_dc = 16'(d / 32'h1_0000); end
        if (op == 'h82) m_fl = 11'(d % 32'h800);
      end
      if (was_armed && cd) m_armed = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("soft_reset", soft_reset, m_srst);
    check("arm", arm, m_arm);
    check("armed", armed, m_armed);
    check("wr_mask", wr_mask, m_mask);
    check("wr_value", wr_value, m_val);
    check("wr_config", wr_config, m_cfg);
    check("wr_data", wr_data, m_wdata);
    check("divider", divider, m_div);
    check("read_count", read_count, m_rc);
    check("delay_count", delay_count, m_dc);
    check("flags", flags, m_fl);
  endtask

  task automatic step(input logic e, input logic [39:0] c, input logic cd);
    execute = e; cmd = c; capture_done = cd;
    @(posedge clock);
    if (!reset_n) m_reset(); else model(e, c, cd);
    #1;
    compare_all();
    n_srst += int'(soft_reset);
    n_arm  += int'(arm);
    n_mask += int'(wr_mask != 4'b0);
  endtask

  task automatic send(input logic [7:0] op, input logic [31:0] d);
    step(1'b1, {d, op}, 1'b0);
    step(1'b0, {d, op}, 1'b0);
  endtask

  function automatic logic [7:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 2) return 8'h00;
    if (r == 3) return 8'h01;
    if (r == 4) return 8'h80 + 8'($urandom_range(0, 2));
    if (r <= 6) return 8'hC0 + 8'($urandom_range(0, 15));
    if (r == 7) return ($urandom_range(0, 1) != 0) ? 8'h11 : 8'h13;
    return 8'($urandom);
  endfunction

  initial begin
    m_reset();
    #1;
    compare_all();
    #20 reset_n = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    send(8'h80, 32'hAB12_3456);
    check("div_load", divider, 24'h12_3456);
    send(8'h81, 32'h0020_0040);
    check("read_count_load", read_count, 16'h0040);
    check("delay_count_load", delay_count, 16'h0020);
    n_mask = 0;
    for (int i = 0; i < 10; i++) step(1'b1, {32'hDEAD_BEEF, 8'hC8}, 1'b0);
    step(1'b0, {32'hDEAD_BEEF, 8'hC8}, 1'b0);
    check("mask_pulse_cycles", n_mask, 1);
    check("mask_wr_data", wr_data, 32'hDEAD_BEEF);
    send(8'h02, 32'h0);
    n_srst = 0;
    for (int i = 0; i < 4; i++) send(8'h00, 32'h0);
    send(8'h82, 32'h0000_07FF);
    check("flags_load", flags, 11'h7FF);
    for (int i = 0; i < 4; i++) send(8'h00, 32'h0);
    check("srst_before_fifth", n_srst, 0);
    send(8'h00, 32'h0);
    check("srst_once", n_srst, 1);
    check("srst_clears_flags", flags, 11'h0);
    n_arm = 0;
    send(8'h01, 32'h0);
    check("armed_after_arm", armed, 1'b1);
    send(8'h01, 32'h0);
    check("arm_once", n_arm, 1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    check("armed_cleared", armed, 1'b0);
    send(8'h01, 32'h0);
    send(8'h80, 32'h0055_AA11);
    execute = 1'b1; cmd = {32'h0011_2233, 8'h80};
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    compare_all();
    for (int i = 0; i < 3; i++) step(1'b1, {32'h0011_2233, 8'h80}, 1'b0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, {32'h0011_2233, 8'h80}, 1'b0);
    check("no_accept_held", divider, DIV_RST);
    step(1'b0, {32'h0011_2233, 8'h80}, 1'b0);
    step(1'b1, {32'h0011_2233, 8'h80}, 1'b0);
    check("accept_after_toggle", divider, 24'h11_2233);
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), {32'($urandom), rand_op()}, ($urandom_range(0, 5) == 0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cmd_decoder.md
CMD_DECODER -- requirements
Module: cmd_decoder

Interface
REQ-001 Parameter: DIV_RESET, 24'd0, divider value loaded at reset and on soft reset.
REQ-002 Parameter: RESET_REPEAT, 5, number of consecutive 0x00 opcodes that trigger a soft reset.
REQ-003 Port: clock, in, 1, the single system clock; every register samples on its rising edge.
REQ-004 Port: reset_n, in, 1, asynchronous active-low reset.
REQ-005 Port: execute, in, 1, command-valid level from the UART stage; may stay high for several cycles.
REQ-006 Port: cmd, in, 40, {opdata[31:0], opcode[7:0]} from the UART stage.
REQ-007 Port: capture_done, in, 1, one-cycle pulse from the sampler marking the end of capture.
REQ-008 Port: soft_reset, out, 1, one-cycle pulse.
REQ-009 Port: arm, out, 1, one-cycle pulse that starts a capture.
REQ-010 Port: armed, out, 1, level; high while a capture is pending or running.
REQ-011 Port: wr_mask, out, 4, one-hot write strobes for trigger stages 0-3.
REQ-012 Port: wr_value, out, 4, one-hot write strobes for trigger stages 0-3.
REQ-013 Port: wr_config, out, 4, one-hot write strobes for trigger stages 0-3.
REQ-014 Port: wr_data, out, 32, registered copy of opdata; valid while any strobe is high.
REQ-015 Port: divider, out, 24, sample-rate divider register.
REQ-016 Port: read_count, out, 16, sample read count register.
REQ-017 Port: delay_count, out, 16, post-trigger delay register.
REQ-018 Port: flags, out, 11, flags register.

Function
REQ-019 A command is accepted only on the rising edge of execute (execute high and execute_d low); further cycles of a held execute are ignored.
REQ-020 Every output responds exactly 1 clock after the acceptance cycle, with all outputs registered.
REQ-021 Opcode 0x01 pulses arm for 1 cycle; it is ignored while armed is already high.
REQ-022 Opcodes 0xC0/0xC4/0xC8/0xCC pulse wr_mask[n], where n = opcode[3:2].
REQ-023 Opcodes 0xC1/0xC5/0xC9/0xCD pulse wr_value[n], where n = opcode[3:2].
REQ-024 Opcodes 0xC2/0xC6/0xCA/0xCE pulse wr_config[n], where n = opcode[3:2].
REQ-025 Opcode 0x80 loads divider from opdata[23:0]; opdata[31:24] are discarded.
REQ-026 Opcode 0x81 loads read_count from opdata[15:0] and delay_count from opdata[31:16].
REQ-027 Opcode 0x82 loads flags from opdata[10:0].
REQ-028 Opcodes 0x02, 0x11, 0x13 and all undefined opcodes cause no output change and no strobe; they are handled by the UART stage.
REQ-029 Soft-reset counter behaviour: an accepted 0x00 increments the 3-bit counter, and any other accepted opcode clears it.
REQ-030 When the counter reaches RESET_REPEAT, soft_reset pulses and the counter clears.
REQ-031 The counter saturates and never wraps.
REQ-032 The soft_reset pulse returns divider to DIV_RESET, clears read_count, delay_count and flags, and forces the FSM to IDLE.
REQ-033 FSM states:
- IDLE: armed = 0; an accepted 0x01 moves to ARMED.
- ARMED: armed = 1; capture_done moves to IDLE.
REQ-034 When capture_done and an accepted 0x01 occur in the same cycle while ARMED, the FSM goes to IDLE and no arm pulse is issued.
REQ-035 Soft reset takes priority over capture_done and over arm.
REQ-036 Strobes are one-hot: at most one strobe, or arm, or soft_reset, is high in any cycle.
REQ-037 wr_data holds its value between commands.

Reset
REQ-038 While reset_n is low, all pulse outputs are 0.
REQ-039 While reset_n is low, the FSM is in IDLE, armed = 0, divider = DIV_RESET, all other registers and the counter are 0, and execute_d = 0.
REQ-040 When reset_n is released while execute is high, no command is accepted until execute falls and rises again, because execute_d is re-armed only by an observed low.

Structure
REQ-041 Opcode constants, the FSM state encoding and field widths live in the shared package sump_pkg.
REQ-042 The block is a single module; there are no sub-modules.

Verification
REQ-043 Send 0x80 with opdata 0xAB123456 -> divider = 0x123456 one cycle later and no strobes.
REQ-044 Send 0x81 with opdata 0x00200040 -> read_count = 0x0040 and delay_count = 0x0020.
REQ-045 Send 0xC8 with opdata 0xDEADBEEF while holding execute high for 10 cycles -> wr_mask = 4'b0100 for exactly 1 cycle and wr_data = 0xDEADBEEF.
REQ-046 Send four 0x00, then 0x82, then five 0x00 -> soft_reset pulses once, only after the fifth 0x00 of the second run.
REQ-047 Send 0x01, then 0x01 again, then pulse capture_done -> one arm pulse; armed goes 1 and then back to 0.
REQ-048 Assert reset_n low mid-ARMED with execute held high -> all outputs take reset values, and no command is accepted after release until execute toggles.
